sha_msg_scheduler: RTL and testbench
====================================

Name: sha_msg_scheduler

Overview:
Dispatches 512-bit message-block streams from a single AXI4-Stream source to NUM_ENGINES parallel message-schedule (wt_unit) engines. Each whole message (all blocks up to and including tlast) is bound to one free engine, chosen round-robin. The block drives that engine's en and sha_type and tracks busy/free per engine until the engine reports completion. It sits between the input packet FIFO and the engine array.

Parameters:
NUM_ENGINES, 4, number of engines served (2..8)
DATA_WIDTH, 512, message-block width in bits
ENG_IDX_W, 2, engine index width; must equal log2(NUM_ENGINES) rounded up

Ports:
axi_aclk  in  1  clock
axi_reset  in  1  asynchronous active-high reset
s_axis_tdata  in  DATA_WIDTH  message block
s_axis_tuser  in  2  sha_type, sampled on first beat: 00 SHA256, 01 SHA512, 10 SHA384, 11 reserved
s_axis_tvalid  in  1  source valid
s_axis_tready  out  1  source ready
s_axis_tlast  in  1  last block of message
m_axis_tdata  out  DATA_WIDTH  shared to all engines, equals s_axis_tdata
m_axis_tlast  out  1  shared, equals s_axis_tlast
m_axis_tvalid  out  NUM_ENGINES  one-hot per-engine valid
m_axis_tready  in  NUM_ENGINES  per-engine ready
eng_en  out  NUM_ENGINES  engine enable
eng_sha_type  out  2*NUM_ENGINES  per-engine sha_type; engine i uses bits [2i+1:2i]
eng_done  in  NUM_ENGINES  single-cycle completion pulse per engine
eng_busy  out  NUM_ENGINES  engine owned by an in-flight message
err_sticky  out  1  reserved-type message dropped or spurious done seen

Behaviour:
- Reset (asynchronous, active-high): state IDLE; s_axis_tready=0; m_axis_tvalid=0; eng_en=0; eng_sha_type=0; eng_busy=0; rr_ptr=0; err_sticky=0. A reset asserted mid-message abandons the message. Beats remaining after reset are treated as a new message.
- States: IDLE, ROUTE, DROP.
- IDLE: s_axis_tready=0. When s_axis_tvalid=1:
  - If s_axis_tuser=11: go to DROP and set err_sticky.
  - Otherwise, if any engine has eng_busy=0: select the first free engine at or after rr_ptr, wrapping modulo NUM_ENGINES, and register it as sel. Set eng_busy[sel]=1 and eng_en[sel]=1. Latch tuser into eng_sha_type[sel]. Go to ROUTE.
  - If all engines are busy: stay in IDLE.
  - Dispatch latency is 1 cycle: no beat is accepted in the selection cycle.
- ROUTE: data passes through combinationally.
  - m_axis_tvalid[sel]=s_axis_tvalid; all other m_axis_tvalid bits are 0.
  - s_axis_tready=m_axis_tready[sel].
  - On a handshake with s_axis_tlast=1: set rr_ptr=(sel+1) mod NUM_ENGINES and go to IDLE.
  - s_axis_tuser is ignored after the first beat.
- DROP: s_axis_tready=1 and all m_axis_tvalid=0. On a handshake with tlast=1, go to IDLE.
- Completion:
  - eng_done[i] while eng_busy[i]=1: clear eng_busy[i] and eng_en[i] next cycle.
  - eng_done[i] while eng_busy[i]=0: ignored, and err_sticky is set.
  - eng_done on the engine currently in ROUTE is honoured, but the route continues until tlast.
  - A freed engine is selectable from the cycle after the done pulse. Selection and done in the same cycle for different engines are independent.
- Single-beat message (tlast on the first beat): IDLE to ROUTE, one beat, back to IDLE.
- err_sticky is cleared only by reset.

Optional Feature:
SHA_MSG_SCHEDULER_STATS_EN:
- Defined: adds ports stat_msgs (out, 32) and stat_blocks (out, 32).
  - stat_msgs counts messages dispatched to an engine, incremented on ROUTE entry.
  - stat_blocks counts blocks accepted in ROUTE.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Three-block SHA256 message (tuser=00), all readies 1 -> engine 0 selected; eng_en=0001; eng_sha_type[1:0]=00; m_axis_tvalid=0001 for 3 beats; rr_ptr=1 afterwards; eng_busy=0001 until eng_done[0].
- Four back-to-back single-block messages with types 00,01,10,00 and no done pulses -> dispatched to engines 0,1,2,3 in order; eng_busy=1111; a fifth message stalls with s_axis_tready=0 until eng_done[2] pulses, then goes to engine 2.
- Backpressure: m_axis_tready[1]=0 for 5 cycles mid-message on engine 1 -> s_axis_tready=0 for those cycles; no beat lost or duplicated; data sequence unchanged.
- Reserved type: message with tuser=11 and 2 beats -> both beats consumed; m_axis_tvalid stays 0; err_sticky=1; no eng_busy change.
- Spurious eng_done[3] while idle -> err_sticky=1; eng_busy unchanged. Separately, assert reset mid-ROUTE -> all outputs return to reset values asynchronously.
- With SHA_MSG_SCHEDULER_STATS_EN defined, send 2 messages of 3 and 1 blocks -> stat_msgs=2, stat_blocks=4.

Source files
------------

// File: rtl/sha_msg_scheduler.sv
// rtl/sha_msg_scheduler.sv - binds each AXI-Stream message to a free SHA schedule engine, round-robin.
// Optional per-message/per-block counters are enabled by defining SHA_MSG_SCHEDULER_STATS_EN.
module sha_msg_scheduler #(
    parameter int NUM_ENGINES = 4,
    parameter int DATA_WIDTH  = 512,
    parameter int ENG_IDX_W   = 2
) (
    input  logic                     axi_aclk,
    input  logic                     axi_reset,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [1:0]               s_axis_tuser,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic                     m_axis_tlast,
    output logic [NUM_ENGINES-1:0]   m_axis_tvalid,
    input  logic [NUM_ENGINES-1:0]   m_axis_tready,
    output logic [NUM_ENGINES-1:0]   eng_en,
    output logic [2*NUM_ENGINES-1:0] eng_sha_type,
    input  logic [NUM_ENGINES-1:0]   eng_done,
    output logic [NUM_ENGINES-1:0]   eng_busy,
    output logic                     err_sticky
`ifdef SHA_MSG_SCHEDULER_STATS_EN
    ,
    output logic [31:0]              stat_msgs,
    output logic [31:0]              stat_blocks
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t                   state_q;
    logic [ENG_IDX_W-1:0]     sel_q;
    logic [ENG_IDX_W-1:0]     rr_ptr_q;
    logic [NUM_ENGINES-1:0]   busy_q, busy_d;
    logic [NUM_ENGINES-1:0]   en_q, en_d;
    logic [2*NUM_ENGINES-1:0] sha_type_q, sha_type_d;
    logic                     err_q;

    logic                     found;
    logic [ENG_IDX_W-1:0]     pick;
    logic [ENG_IDX_W:0]       cand_sum;
    logic [ENG_IDX_W-1:0]     cand;
    logic                     dispatch;
    logic                     route_hs;
    logic                     drop_start;
    logic                     spurious;
    logic [NUM_ENGINES-1:0]   done_hit;
    logic [NUM_ENGINES-1:0]   sel_onehot;

    // First free engine at or after rr_ptr, wrapping modulo NUM_ENGINES.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        cand_sum = '0;
        cand     = '0;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + (ENG_IDX_W+1)'(k);
            if (cand_sum >= (ENG_IDX_W+1)'(NUM_ENGINES)) begin
                cand_sum = cand_sum - (ENG_IDX_W+1)'(NUM_ENGINES);
            end
            cand = cand_sum[ENG_IDX_W-1:0];
            if (!found && !busy_q[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign dispatch   = (state_q == ST_IDLE) && s_axis_tvalid && (s_axis_tuser != 2'b11) && found;
    assign drop_start = (state_q == ST_IDLE) && s_axis_tvalid && (s_axis_tuser == 2'b11);
    assign route_hs   = (state_q == ST_ROUTE) && s_axis_tvalid && m_axis_tready[sel_q];
    assign done_hit   = eng_done & busy_q;
    assign spurious   = |(eng_done & ~busy_q);
    assign sel_onehot = dispatch ? (NUM_ENGINES'(1) << pick) : '0;

    always_comb begin
        busy_d     = (busy_q & ~done_hit) | sel_onehot;
        en_d       = (en_q & ~done_hit) | sel_onehot;
        sha_type_d = sha_type_q;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (sel_onehot[i]) begin
                sha_type_d[2*i +: 2] = s_axis_tuser;
            end
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            rr_ptr_q   <= '0;
            busy_q     <= '0;
            en_q       <= '0;
            sha_type_q <= '0;
            err_q      <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            en_q       <= en_d;
            sha_type_q <= sha_type_d;
            if (spurious || drop_start) begin
                err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (drop_start) begin
                        state_q <= ST_DROP;
                    end else if (dispatch) begin
                        sel_q   <= pick;
                        state_q <= ST_ROUTE;
                    end
                end
                ST_ROUTE: begin
                    if (route_hs && s_axis_tlast) begin
                        rr_ptr_q <= (sel_q == ENG_IDX_W'(NUM_ENGINES-1)) ? '0 : sel_q + 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (s_axis_tvalid && s_axis_tlast) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Routing is combinational so a beat is accepted in the same cycle the engine is ready.
    always_comb begin
        m_axis_tvalid = '0;
        s_axis_tready = 1'b0;
        case (state_q)
            ST_ROUTE: begin
                m_axis_tvalid[sel_q] = s_axis_tvalid;
                s_axis_tready        = m_axis_tready[sel_q];
            end
            ST_DROP:  s_axis_tready = 1'b1;
            default:  s_axis_tready = 1'b0;
        endcase
    end

    assign m_axis_tdata = s_axis_tdata;
    assign m_axis_tlast = s_axis_tlast;
    assign eng_en       = en_q;
    assign eng_busy     = busy_q;
    assign eng_sha_type = sha_type_q;
    assign err_sticky   = err_q;

`ifdef SHA_MSG_SCHEDULER_STATS_EN
    logic [31:0] stat_msgs_q;
    logic [31:0] stat_blocks_q;

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            stat_msgs_q   <= '0;
            stat_blocks_q <= '0;
        end else begin
            if (dispatch) begin
                stat_msgs_q <= stat_msgs_q + 32'd1;
            end
            if (route_hs) begin
                stat_blocks_q <= stat_blocks_q + 32'd1;
            end
        end
    end

    assign stat_msgs   = stat_msgs_q;
    assign stat_blocks = stat_blocks_q;
`endif

endmodule

// File: tb/tb_sha_msg_scheduler.sv
// tb/tb_sha_msg_scheduler.sv - directed self-checking bench for sha_msg_scheduler.
module tb_sha_msg_scheduler;

    logic         clk;
    logic         rst;
    logic [511:0] s_tdata;
    logic [1:0]   s_tuser;
    logic         s_tvalid;
    logic         s_tready;
    logic         s_tlast;
    logic [511:0] m_tdata;
    logic         m_tlast;
    logic [3:0]   m_tvalid;
    logic [3:0]   m_tready;
    logic [3:0]   eng_en;
    logic [7:0]   eng_sha_type;
    logic [3:0]   eng_done;
    logic [3:0]   eng_busy;
    logic         err_sticky;
`ifdef SHA_MSG_SCHEDULER_STATS_EN
    logic [31:0]  stat_msgs;
    logic [31:0]  stat_blocks;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int hs_cnt  = 0;
    int hs_base;

    sha_msg_scheduler #(.NUM_ENGINES(4), .DATA_WIDTH(512), .ENG_IDX_W(2)) dut (
        .axi_aclk      (clk),
        .axi_reset     (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .eng_en        (eng_en),
        .eng_sha_type  (eng_sha_type),
        .eng_done      (eng_done),
        .eng_busy      (eng_busy),
        .err_sticky    (err_sticky)
`ifdef SHA_MSG_SCHEDULER_STATS_EN
        ,
        .stat_msgs     (stat_msgs),
        .stat_blocks   (stat_blocks)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (s_tvalid && s_tready) hs_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [63:0] d, input logic last,
                        input logic [1:0] user, input logic [3:0] exp_v);
        bit got;
        got      = 1'b0;
        s_tdata  = {8{d}};
        s_tlast  = last;
        s_tuser  = user;
        s_tvalid = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            #1;
            if (s_tready) begin
                check({tag, "_tvalid"}, 64'(m_tvalid), 64'(exp_v));
                check({tag, "_tdata"}, m_tdata[511:448], d);
                check({tag, "_tlast"}, 64'(m_tlast), 64'(last));
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!got) check({tag, "_timeout"}, 64'd0, 64'd1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic pulse_done(input logic [3:0] v);
        eng_done = v;
        @(posedge clk);
        #1;
        eng_done = 4'b0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        s_tdata  = '0;
        s_tuser  = 2'b00;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 4'b1111;
        eng_done = 4'b0000;
        #2;
        check("rst_tready", 64'(s_tready), 64'd0);
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_en", 64'(eng_en), 64'd0);
        check("rst_sha", 64'(eng_sha_type), 64'd0);
        check("rst_busy", 64'(eng_busy), 64'd0);
        check("rst_err", 64'(err_sticky), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Three-block SHA256 message lands on engine 0.
        s_tvalid = 1'b1;
        s_tuser  = 2'b00;
        #1;
        check("t1_sel_cycle_tready", 64'(s_tready), 64'd0);
        push("t1_b0", 64'hA1, 1'b0, 2'b00, 4'b0001);
        check("t1_en", 64'(eng_en), 64'h1);
        push("t1_b1", 64'hA2, 1'b0, 2'b00, 4'b0001);
        push("t1_b2", 64'hA3, 1'b1, 2'b00, 4'b0001);
        check("t1_busy", 64'(eng_busy), 64'h1);
        check("t1_sha", 64'(eng_sha_type[1:0]), 64'h0);
        // rr_ptr=1 shows as next message going to engine 1.
        push("t1_next", 64'hA4, 1'b1, 2'b01, 4'b0010);
        check("t1_busy2", 64'(eng_busy), 64'h3);
        pulse_done(4'b0001);
        check("t1_done_busy", 64'(eng_busy), 64'h2);
        check("t1_done_en", 64'(eng_en), 64'h2);

        // Four single-block messages fill all engines, fifth waits for a done.
        do_reset();
        push("t2_m0", 64'hB0, 1'b1, 2'b00, 4'b0001);
        push("t2_m1", 64'hB1, 1'b1, 2'b01, 4'b0010);
        push("t2_m2", 64'hB2, 1'b1, 2'b10, 4'b0100);
        push("t2_m3", 64'hB3, 1'b1, 2'b00, 4'b1000);
        check("t2_busy", 64'(eng_busy), 64'hF);
        check("t2_sha", 64'(eng_sha_type), 64'h24);
        s_tdata  = {8{64'hB4}};
        s_tuser  = 2'b01;
        s_tlast  = 1'b1;
        s_tvalid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t2_stall_tready", 64'(s_tready), 64'd0);
            @(posedge clk);
            #1;
        end
        pulse_done(4'b0100);
        check("t2_freed_busy", 64'(eng_busy), 64'hB);
        push("t2_m4", 64'hB4, 1'b1, 2'b01, 4'b0100);
        check("t2_sha2", 64'(eng_sha_type), 64'h14);
        check("t2_err", 64'(err_sticky), 64'd0);

        // Backpressure from engine 1 mid-message.
        do_reset();
        push("t3_m0", 64'hC0, 1'b1, 2'b00, 4'b0001);
        hs_base = hs_cnt;
        push("t3_b0", 64'hC1, 1'b0, 2'b01, 4'b0010);
        m_tready = 4'b1101;
        s_tdata  = {8{64'hC2}};
        s_tvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("t3_bp_tready", 64'(s_tready), 64'd0);
            check("t3_bp_tvalid", 64'(m_tvalid), 64'h2);
            @(posedge clk);
            #1;
        end
        m_tready = 4'b1111;
        push("t3_b1", 64'hC2, 1'b0, 2'b01, 4'b0010);
        push("t3_b2", 64'hC3, 1'b1, 2'b01, 4'b0010);
        check("t3_beats", 64'(hs_cnt - hs_base), 64'd3);

        // Reserved type is consumed and dropped.
        push("t4_b0", 64'hD0, 1'b0, 2'b11, 4'b0000);
        check("t4_err", 64'(err_sticky), 64'd1);
        push("t4_b1", 64'hD1, 1'b1, 2'b11, 4'b0000);
        check("t4_busy", 64'(eng_busy), 64'h3);
        check("t4_tready_idle", 64'(s_tready), 64'd0);

        // Spurious done while idle, then asynchronous reset mid-route.
        do_reset();
        check("t5_err0", 64'(err_sticky), 64'd0);
        pulse_done(4'b1000);
        check("t5_spur_err", 64'(err_sticky), 64'd1);
        check("t5_spur_busy", 64'(eng_busy), 64'd0);
        push("t5_b0", 64'hE0, 1'b0, 2'b10, 4'b0001);
        s_tvalid = 1'b1;
        #1;
        check("t5_route_tvalid", 64'(m_tvalid), 64'h1);
        #1;
        rst = 1'b1;
        #1;
        check("t5_arst_tready", 64'(s_tready), 64'd0);
        check("t5_arst_tvalid", 64'(m_tvalid), 64'd0);
        check("t5_arst_en", 64'(eng_en), 64'd0);
        check("t5_arst_busy", 64'(eng_busy), 64'd0);
        check("t5_arst_sha", 64'(eng_sha_type), 64'd0);
        check("t5_arst_err", 64'(err_sticky), 64'd0);
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef SHA_MSG_SCHEDULER_STATS_EN
        do_reset();
        check("t6_msgs0", 64'(stat_msgs), 64'd0);
        push("t6_a0", 64'hF0, 1'b0, 2'b00, 4'b0001);
        push("t6_a1", 64'hF1, 1'b0, 2'b00, 4'b0001);
        push("t6_a2", 64'hF2, 1'b1, 2'b00, 4'b0001);
        push("t6_b0", 64'hF3, 1'b1, 2'b01, 4'b0010);
        check("t6_msgs", 64'(stat_msgs), 64'd2);
        check("t6_blocks", 64'(stat_blocks), 64'd4);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
